icache_line_fill_responder: RTL and testbench

- Memory-side responder for the instruction-cache line-fill protocol. The cache FSM issues one line request on a miss; this block reads the line's words from the backing instruction memory and streams them back one beat at a time.
- Word order is critical-word-first with wrap-around. The response channel supports backpressure and an abort used on pipeline flush/redirect.
- Sits between the IR cache controller and the synchronous instruction memory read port.

---
 rtl/icache_line_fill_responder.sv | 186 ++++++++++++++++++
 tb/tb_icache_line_fill_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_line_fill_responder.sv
// Memory-side line-fill responder for the instruction cache.
// Reads one cache line from synchronous instruction memory and streams it back
// critical-word-first with wrap-around. Supports response backpressure, abort
// on flush/redirect, and an error beat for out-of-range requests.
module icache_line_fill_responder #(
  parameter int unsigned LINE_WORDS  = 8,
  parameter int unsigned MEM_WORDS   = 16384,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          REQ_VALID,
  output logic                          REQ_READY,
  input  logic [31:0]                   REQ_ADDR,
  input  logic                          ABORT,
  output logic                          MEM_RDEN,
  output logic [$clog2(MEM_WORDS)-1:0]  MEM_ADDR,
  input  logic [31:0]                   MEM_DATA,
  output logic                          RSP_VALID,
  input  logic                          RSP_READY,
  output logic [31:0]                   RSP_DATA,
  output logic [$clog2(LINE_WORDS)-1:0] RSP_WORD_IDX,
  output logic                          RSP_LAST,
  output logic                          RSP_ERR
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam int unsigned IW        = $clog2(LINE_WORDS);
  localparam int unsigned BW        = AW - IW;
  localparam int unsigned WCW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned WAIT_LAST = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam int unsigned BEAT_LAST = LINE_WORDS - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_CAPT  = 3'd3,
    S_RESP  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [BW-1:0]    line_base;
  logic [IW-1:0]    start_idx;
  logic [IW-1:0]    cur_idx;
  logic [IW-1:0]    beat_cnt;
  logic [WCW-1:0]   wait_cnt;
  logic [31:0]      data_reg;

  logic             accept;
  logic             req_oor;
  logic             last_beat;
  logic             wait_done;
  logic             busy_abort;
  logic             unused_addr_bits;

  // Byte-offset bits of the request address carry no information here
  assign unused_addr_bits = ^REQ_ADDR[1:0];

  // Request handshake and request decode
  assign accept     = REQ_VALID & REQ_READY;
  assign req_oor    = (REQ_ADDR[31:2] >= 30'(MEM_WORDS));
  assign last_beat  = (beat_cnt == IW'(BEAT_LAST));
  assign wait_done  = (wait_cnt == WCW'(WAIT_LAST));
  assign busy_abort = (state != S_IDLE) & ABORT;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort from any busy state overrides the normal flow
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_oor) begin
            state_nxt = S_ERR;
          end else if (WAIT_CYCLES > 0) begin
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_ISSUE;
          end
        end
      end
      S_WAIT: begin
        if (wait_done) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_CAPT;
      S_CAPT:  state_nxt = S_RESP;
      S_RESP: begin
        if (RSP_READY) begin
          state_nxt = last_beat ? S_IDLE : S_ISSUE;
        end
      end
      S_ERR: begin
        if (RSP_READY) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (busy_abort) begin
      state_nxt = S_IDLE;
    end
  end

  // Fill context: line base, word indices, beat/wait counters, captured data
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      line_base <= '0;
      start_idx <= '0;
      cur_idx   <= '0;
      beat_cnt  <= '0;
      wait_cnt  <= '0;
      data_reg  <= '0;
    end else if (accept) begin
      line_base <= REQ_ADDR[2+AW-1:2+IW];
      start_idx <= REQ_ADDR[2+IW-1:2];
      cur_idx   <= REQ_ADDR[2+IW-1:2];
      beat_cnt  <= '0;
      wait_cnt  <= '0;
      data_reg  <= '0;
    end else if (busy_abort) begin
      data_reg  <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          wait_cnt <= WCW'(wait_cnt + 1'b1);
        end
        S_CAPT: begin
          data_reg <= MEM_DATA;
        end
        S_RESP: begin
          if (RSP_READY && !last_beat) begin
            cur_idx  <= IW'(cur_idx + 1'b1);
            beat_cnt <= IW'(beat_cnt + 1'b1);
          end
        end
        default: ;
      endcase
    end
  end

  // State-decoded outputs; only registered context feeds the data fields
  always_comb begin
    REQ_READY    = (state == S_IDLE) & ~ABORT;
    MEM_RDEN     = 1'b0;
    MEM_ADDR     = '0;
    RSP_VALID    = 1'b0;
    RSP_DATA     = '0;
    RSP_WORD_IDX = '0;
    RSP_LAST     = 1'b0;
    RSP_ERR      = 1'b0;
    case (state)
      S_ISSUE: begin
        MEM_RDEN = 1'b1;
        MEM_ADDR = {line_base, cur_idx};
      end
      S_RESP: begin
        RSP_VALID    = 1'b1;
        RSP_DATA     = data_reg;
        RSP_WORD_IDX = cur_idx;
        RSP_LAST     = last_beat;
      end
      S_ERR: begin
        RSP_VALID    = 1'b1;
        RSP_WORD_IDX = start_idx;
        RSP_LAST     = 1'b1;
        RSP_ERR      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache_line_fill_responder.sv
// Scoreboard bench for icache_line_fill_responder with default parameters.
module tb_icache_line_fill_responder;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [31:0] REQ_ADDR = '0;
  logic        ABORT = 1'b0;
  logic        MEM_RDEN;
  logic [13:0] MEM_ADDR;
  logic [31:0] MEM_DATA = '0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b1;
  logic [31:0] RSP_DATA;
  logic [2:0]  RSP_WORD_IDX;
  logic        RSP_LAST;
  logic        RSP_ERR;

  icache_line_fill_responder dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .REQ_VALID    (REQ_VALID),
    .REQ_READY    (REQ_READY),
    .REQ_ADDR     (REQ_ADDR),
    .ABORT        (ABORT),
    .MEM_RDEN     (MEM_RDEN),
    .MEM_ADDR     (MEM_ADDR),
    .MEM_DATA     (MEM_DATA),
    .RSP_VALID    (RSP_VALID),
    .RSP_READY    (RSP_READY),
    .RSP_DATA     (RSP_DATA),
    .RSP_WORD_IDX (RSP_WORD_IDX),
    .RSP_LAST     (RSP_LAST),
    .RSP_ERR      (RSP_ERR)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  idx;
    logic        last;
    logic        err;
  } beat_t;

  beat_t exp_q[$];
  int    beat_cyc[$];
  int    rd_cyc[$];
  int    rd_addr[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    acc_cyc = 0;
  int    rd_cnt  = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  // Synchronous memory: word n holds 0xA000_0000 + n
  always @(posedge CLK) begin
    if (MEM_RDEN) MEM_DATA <= 32'hA000_0000 + 32'(MEM_ADDR);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: beats popped against scoreboard, memory reads logged
  always @(negedge CLK) begin
    if (RST_N && MEM_RDEN) begin
      rd_cnt++;
      rd_cyc.push_back(cyc);
      rd_addr.push_back(int'(MEM_ADDR));
    end
    if (RST_N && RSP_VALID && RSP_READY) begin
      beat_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("stray_beat_qsize", 32'(exp_q.size()), 32'd1);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_data", RSP_DATA, e.data);
        check("beat_idx",  32'(RSP_WORD_IDX), 32'(e.idx));
        check("beat_last", 32'(RSP_LAST), 32'(e.last));
        check("beat_err",  32'(RSP_ERR), 32'(e.err));
      end
    end
  end

  // Drive one request, wait for acceptance, push the expected beat sequence
  task automatic do_req(input logic [31:0] addr);
    int n;
    logic [29:0] word;
    logic [2:0]  start;
    beat_t       b;
    n = 0;
    while (!REQ_READY && n < 100) begin
      @(posedge CLK); #1; n++;
    end
    REQ_VALID = 1'b1;
    REQ_ADDR  = addr;
    @(negedge CLK);
    check("req_accept", 32'(REQ_READY), 32'd1);
    acc_cyc = cyc;
    word  = addr[31:2];
    start = addr[4:2];
    if (word >= 30'd16384) begin
      b.data = '0; b.idx = start; b.last = 1'b1; b.err = 1'b1;
      exp_q.push_back(b);
    end else begin
      for (int k = 0; k < 8; k++) begin
        b.idx  = 3'(start + 3'(k));
        b.data = 32'hA000_0000 + 32'({word[29:3], 3'b000}) + 32'(b.idx);
        b.last = (k == 7);
        b.err  = 1'b0;
        exp_q.push_back(b);
      end
    end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    REQ_ADDR  = 32'hDEAD_BEEC;
  endtask

  // Advance to 1 time unit after the edge that starts cycle n after acceptance
  task automatic wait_to(input int n);
    while (cyc - acc_cyc < n) begin
      @(posedge CLK); #1;
    end
  endtask

  // Wait for all expected beats and return to idle, bounded
  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !REQ_READY) && n < 200) begin
      @(negedge CLK); n++;
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"}, 32'(REQ_READY), 32'd1);
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rd0;
    logic [31:0] hold_data;
    logic [2:0]  hold_idx;

    // Reset state
    #13;
    check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("rst_mem_rden",  32'(MEM_RDEN), 32'd0);
    check("rst_rsp_last",  32'(RSP_LAST), 32'd0);
    check("rst_rsp_err",   32'(RSP_ERR), 32'd0);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check("rst_req_ready", 32'(REQ_READY), 32'd1);

    // Aligned line, timing of reads and beats
    beat_cyc.delete(); rd_cyc.delete(); rd_addr.delete();
    do_req(32'h0000_0040);
    wait_to(26);
    @(negedge CLK);
    check("t1_busy_c26", 32'(REQ_READY), 32'd0);
    wait_to(27);
    @(negedge CLK);
    check("t1_ready_c27", 32'(REQ_READY), 32'd1);
    check("t1_nbeats", 32'(beat_cyc.size()), 32'd8);
    check("t1_nreads", 32'(rd_cyc.size()), 32'd8);
    check("t1_rd0_cyc", 32'(rd_cyc[0] - acc_cyc), 32'd3);
    check("t1_rd0_addr", 32'(rd_addr[0]), 32'h10);
    for (int i = 0; i < 8 && i < beat_cyc.size(); i++) begin
      check("t1_beat_cyc", 32'(beat_cyc[i] - acc_cyc), 32'(5 + 3 * i));
    end
    @(posedge CLK); #1;

    // Critical word at the last index wraps around the line
    do_req(32'h0000_005C);
    wait_drain("t2");

    // Backpressure on beat 3 for five cycles
    do_req(32'h0000_0040);
    wait_to(14);
    RSP_READY = 1'b0;
    rd0 = rd_cnt;
    @(negedge CLK);
    hold_data = RSP_DATA;
    hold_idx  = RSP_WORD_IDX;
    check("t3_stall_idx0", 32'(hold_idx), 32'd3);
    check("t3_stall_data0", hold_data, 32'hA000_0013);
    for (int i = 1; i < 5; i++) begin
      @(negedge CLK);
      check("t3_stall_valid", 32'(RSP_VALID), 32'd1);
      check("t3_stall_data", RSP_DATA, hold_data);
      check("t3_stall_idx", 32'(RSP_WORD_IDX), 32'(hold_idx));
    end
    wait_to(19);
    check("t3_no_read_in_stall", 32'(rd_cnt - rd0), 32'd0);
    RSP_READY = 1'b1;
    wait_drain("t3");

    // Abort during the wait phase of beat 0
    do_req(32'h0000_0040);
    wait_to(1);
    ABORT = 1'b1;
    rd0 = rd_cnt;
    @(negedge CLK);
    check("t4a_ready_in_abort", 32'(REQ_READY), 32'd0);
    wait_to(2);
    ABORT = 1'b0;
    @(negedge CLK);
    check("t4a_valid_after", 32'(RSP_VALID), 32'd0);
    check("t4a_ready_after", 32'(REQ_READY), 32'd1);
    exp_q.delete();
    repeat (10) @(negedge CLK);
    check("t4a_no_read", 32'(rd_cnt - rd0), 32'd0);

    // Abort in idle blocks acceptance
    @(posedge CLK); #1;
    REQ_VALID = 1'b1;
    REQ_ADDR  = 32'h0000_0040;
    ABORT     = 1'b1;
    @(negedge CLK);
    check("t4b_ready_blocked", 32'(REQ_READY), 32'd0);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    ABORT     = 1'b0;
    repeat (10) @(negedge CLK);
    check("t4b_no_fill", 32'(rd_cnt - rd0), 32'd0);
    @(posedge CLK); #1;

    // Abort during the response of beat 4 while stalled
    do_req(32'h0000_0040);
    wait_to(17);
    RSP_READY = 1'b0;
    ABORT     = 1'b1;
    @(negedge CLK);
    check("t4c_valid_b4", 32'(RSP_VALID), 32'd1);
    check("t4c_idx_b4", 32'(RSP_WORD_IDX), 32'd4);
    wait_to(18);
    ABORT     = 1'b0;
    RSP_READY = 1'b1;
    @(negedge CLK);
    check("t4c_valid_after", 32'(RSP_VALID), 32'd0);
    check("t4c_rden_after", 32'(MEM_RDEN), 32'd0);
    check("t4c_ready_after", 32'(REQ_READY), 32'd1);
    check("t4c_remaining", 32'(exp_q.size()), 32'd4);
    exp_q.delete();
    @(posedge CLK); #1;
    do_req(32'h0000_0080);
    wait_drain("t4c_clean");

    // Out-of-range requests produce a single error beat and no read
    rd0 = rd_cnt;
    do_req(32'h0001_0000);
    wait_drain("t5a");
    do_req(32'hFFFF_FFFC);
    wait_drain("t5b");
    check("t5_no_read", 32'(rd_cnt - rd0), 32'd0);

    // Asynchronous reset while a beat is presented
    RSP_READY = 1'b0;
    do_req(32'h0000_0040);
    wait_to(5);
    check("t6_valid_before", 32'(RSP_VALID), 32'd1);
    #3;
    RST_N = 1'b0;
    #1;
    check("t6_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("t6_rsp_data",  RSP_DATA, 32'd0);
    check("t6_rsp_idx",   32'(RSP_WORD_IDX), 32'd0);
    check("t6_rsp_last",  32'(RSP_LAST), 32'd0);
    check("t6_rsp_err",   32'(RSP_ERR), 32'd0);
    check("t6_mem_rden",  32'(MEM_RDEN), 32'd0);
    check("t6_mem_addr",  32'(MEM_ADDR), 32'd0);
    exp_q.delete();
    rd0 = rd_cnt;
    repeat (2) @(posedge CLK);
    #3;
    RST_N = 1'b1;
    RSP_READY = 1'b1;
    repeat (40) @(negedge CLK);
    check("t6_ready_after", 32'(REQ_READY), 32'd1);
    check("t6_no_read_after", 32'(rd_cnt - rd0), 32'd0);
    @(posedge CLK); #1;
    do_req(32'h0000_005C);
    wait_drain("t6_post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
